// File: rtl/reg_rename_table_if.sv
// Dispatch/commit bus of the rename table: lookup/rename request, registered
// operand response and the ROB commit write. The master drives requests and commits.
interface reg_rename_table_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int TAG_W  = 4,
  parameter int ID_W   = 4
);
  logic              cdb_valid;
  logic [REG_AW-1:0] cdb_dest;
  logic [XLEN-1:0]   cdb_value;
  logic [TAG_W-1:0]  cdb_tag;

  logic              req_valid;
  logic [ID_W-1:0]   req_id;
  logic              req_rs1_en;
  logic              req_rs2_en;
  logic [REG_AW-1:0] req_rs1;
  logic [REG_AW-1:0] req_rs2;
  logic              req_rd_en;
  logic [REG_AW-1:0] req_rd;
  logic [TAG_W-1:0]  req_rd_tag;

  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_rs1_busy;
  logic              rsp_rs2_busy;
  logic [TAG_W-1:0]  rsp_rs1_tag;
  logic [TAG_W-1:0]  rsp_rs2_tag;
  logic [XLEN-1:0]   rsp_rs1_value;
  logic [XLEN-1:0]   rsp_rs2_value;

  modport master (
    output cdb_valid, cdb_dest, cdb_value, cdb_tag,
    output req_valid, req_id, req_rs1_en, req_rs2_en, req_rs1, req_rs2,
    output req_rd_en, req_rd, req_rd_tag,
    input  rsp_valid, rsp_id, rsp_rs1_busy, rsp_rs2_busy,
    input  rsp_rs1_tag, rsp_rs2_tag, rsp_rs1_value, rsp_rs2_value
  );

  modport slave (
    input  cdb_valid, cdb_dest, cdb_value, cdb_tag,
    input  req_valid, req_id, req_rs1_en, req_rs2_en, req_rs1, req_rs2,
    input  req_rd_en, req_rd, req_rd_tag,
    output rsp_valid, rsp_id, rsp_rs1_busy, rsp_rs2_busy,
    output rsp_rs1_tag, rsp_rs2_tag, rsp_rs1_value, rsp_rs2_value
  );
endinterface

// File: rtl/reg_rename_table.sv
// Architectural register file + rename table: operand lookup with commit bypass, rd rename.
// Latency 1 cycle (registered response); no backpressure, one request accepted per enabled cycle.
// Optional single branch checkpoint of busy/tag under macro REG_SNAPSHOT_EN.
module reg_rename_table #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int TAG_W  = 4,
  parameter int ID_W   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rdy_i,
  input  logic flush_i,
  input  logic snap_take_i,
  input  logic snap_restore_i,
  reg_rename_table_if.slave bus
);
  localparam int NUM_REGS = 2**REG_AW;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } opnd_t;

  logic [XLEN-1:0]     value_q [NUM_REGS];
  logic [XLEN-1:0]     value_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]    tag_q [NUM_REGS];
  logic [TAG_W-1:0]    tag_d [NUM_REGS];
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  opnd_t               rs1_q, rs1_d, rs2_q, rs2_d;
  logic                restore_ok;
  logic                cdb_hit;

`ifdef REG_SNAPSHOT_EN
  logic [NUM_REGS-1:0] snap_busy_q, snap_busy_d;
  logic [TAG_W-1:0]    snap_tag_q [NUM_REGS];
  logic [TAG_W-1:0]    snap_tag_d [NUM_REGS];
  logic                snap_valid_q, snap_valid_d;
  assign restore_ok = snap_restore_i && snap_valid_q;
`else
  logic unused_snap_take;
  assign unused_snap_take = snap_take_i;
  assign restore_ok = 1'b0;
`endif

  assign cdb_hit = bus.cdb_valid && (bus.cdb_dest != '0);

  function automatic opnd_t lookup(
    input logic              en,
    input logic [REG_AW-1:0] r,
    input logic              b,
    input logic [TAG_W-1:0]  t,
    input logic [XLEN-1:0]   v,
    input logic              hit,
    input logic [REG_AW-1:0] cd,
    input logic [TAG_W-1:0]  ct,
    input logic [XLEN-1:0]   cv
  );
    opnd_t o;
    o = '0;
    if (!en || r == '0) begin
      o = '0;
    end else if (!b) begin
      o.value = v;
    end else if (hit && cd == r && ct == t) begin
      o.value = cv;
    end else begin
      o.busy = 1'b1;
      o.tag  = t;
    end
    return o;
  endfunction

  always_comb begin
    value_d     = value_q;
    busy_d      = busy_q;
    tag_d       = tag_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rs1_d       = '0;
    rs2_d       = '0;
`ifdef REG_SNAPSHOT_EN
    snap_busy_d  = snap_busy_q;
    snap_tag_d   = snap_tag_q;
    snap_valid_d = snap_valid_q;
`endif
    // The committed value always lands, whatever else happens this cycle.
    if (cdb_hit) value_d[bus.cdb_dest] = bus.cdb_value;

    if (flush_i || (snap_restore_i && !restore_ok)) begin
      busy_d = '0;
`ifdef REG_SNAPSHOT_EN
      snap_valid_d = 1'b0;
`endif
    end else if (restore_ok) begin
`ifdef REG_SNAPSHOT_EN
      busy_d = snap_busy_q;
      tag_d  = snap_tag_q;
      if (cdb_hit && snap_tag_q[bus.cdb_dest] == bus.cdb_tag) busy_d[bus.cdb_dest] = 1'b0;
      snap_valid_d = 1'b0;
`endif
    end else begin
      if (cdb_hit && tag_q[bus.cdb_dest] == bus.cdb_tag) busy_d[bus.cdb_dest] = 1'b0;
      // Rename after commit so a same-register rename wins busy/tag.
      if (bus.req_valid && bus.req_rd_en && bus.req_rd != '0) begin
        busy_d[bus.req_rd] = 1'b1;
        tag_d[bus.req_rd]  = bus.req_rd_tag;
      end
      if (bus.req_valid) begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = bus.req_id;
        rs1_d = lookup(bus.req_rs1_en, bus.req_rs1, busy_q[bus.req_rs1], tag_q[bus.req_rs1],
                       value_q[bus.req_rs1], cdb_hit, bus.cdb_dest, bus.cdb_tag, bus.cdb_value);
        rs2_d = lookup(bus.req_rs2_en, bus.req_rs2, busy_q[bus.req_rs2], tag_q[bus.req_rs2],
                       value_q[bus.req_rs2], cdb_hit, bus.cdb_dest, bus.cdb_tag, bus.cdb_value);
      end
`ifdef REG_SNAPSHOT_EN
      if (snap_valid_q && cdb_hit && snap_tag_q[bus.cdb_dest] == bus.cdb_tag)
        snap_busy_d[bus.cdb_dest] = 1'b0;
      if (snap_take_i) begin
        snap_busy_d  = busy_d;
        snap_tag_d   = tag_d;
        snap_valid_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
`ifdef REG_SNAPSHOT_EN
      for (int i = 0; i < NUM_REGS; i++) snap_tag_q[i] <= '0;
      snap_busy_q  <= '0;
      snap_valid_q <= 1'b0;
`endif
    end else if (rdy_i) begin
      value_q     <= value_d;
      busy_q      <= busy_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
`ifdef REG_SNAPSHOT_EN
      snap_busy_q  <= snap_busy_d;
      snap_tag_q   <= snap_tag_d;
      snap_valid_q <= snap_valid_d;
`endif
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_rs1_busy  = rs1_q.busy;
  assign bus.rsp_rs1_tag   = rs1_q.tag;
  assign bus.rsp_rs1_value = rs1_q.value;
  assign bus.rsp_rs2_busy  = rs2_q.busy;
  assign bus.rsp_rs2_tag   = rs2_q.tag;
  assign bus.rsp_rs2_value = rs2_q.value;
endmodule

// File: tb/tb_reg_rename_table.sv
// Directed bench for reg_rename_table; expectations adapt to REG_SNAPSHOT_EN.
module tb_reg_rename_table;
  logic clk = 1'b0;
  logic rst, rdy, flush, snap_take, snap_restore;
  int   n_asrt = 0;
  int   n_fail = 0;

  reg_rename_table_if #(.XLEN(32), .REG_AW(5), .TAG_W(4), .ID_W(4)) bus ();

  reg_rename_table #(.XLEN(32), .REG_AW(5), .TAG_W(4), .ID_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rdy_i          (rdy),
    .flush_i        (flush),
    .snap_take_i    (snap_take),
    .snap_restore_i (snap_restore),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush = 0; snap_take = 0; snap_restore = 0;
    bus.cdb_valid = 0; bus.cdb_dest = 0; bus.cdb_value = 0; bus.cdb_tag = 0;
    bus.req_valid = 0; bus.req_id = 0; bus.req_rs1_en = 0; bus.req_rs2_en = 0;
    bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_rd_en = 0; bus.req_rd = 0; bus.req_rd_tag = 0;
  endtask

  task automatic commit(input logic [4:0] d, input logic [3:0] t, input logic [31:0] v);
    bus.cdb_valid = 1; bus.cdb_dest = d; bus.cdb_tag = t; bus.cdb_value = v;
  endtask

  task automatic req(input logic [3:0] id, input logic e1, input logic [4:0] r1,
                     input logic e2, input logic [4:0] r2,
                     input logic rde, input logic [4:0] rd, input logic [3:0] t);
    bus.req_valid = 1; bus.req_id = id;
    bus.req_rs1_en = e1; bus.req_rs1 = r1; bus.req_rs2_en = e2; bus.req_rs2 = r2;
    bus.req_rd_en = rde; bus.req_rd = rd; bus.req_rd_tag = t;
  endtask

  task automatic test_reset();
    clr(); rdy = 1; rst = 1;
    cyc(); cyc();
    rst = 0;
    n_asrt++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.rsp_valid); end
    n_asrt++; if (bus.rsp_rs1_value !== 32'h0 || bus.rsp_id !== 4'h0) begin n_fail++; $display("FAIL reset_rsp got %h/%h want 0/0", bus.rsp_rs1_value, bus.rsp_id); end
    req(4'h2, 1, 5'd5, 1, 5'd31, 0, 5'd0, 4'd0); cyc(); clr();
    n_asrt++; if ({bus.rsp_rs1_busy, bus.rsp_rs2_busy} !== 2'b00 || bus.rsp_rs1_value !== 32'h0 || bus.rsp_rs2_value !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs got busy %b vals %h %h want 00 0 0", {bus.rsp_rs1_busy, bus.rsp_rs2_busy}, bus.rsp_rs1_value, bus.rsp_rs2_value); end
  endtask

  task automatic test_commit_read();
    clr(); commit(5'd5, 4'd3, 32'h1234); cyc();
    clr(); req(4'h1, 1, 5'd5, 0, 5'd5, 0, 5'd0, 4'd0); cyc(); clr();
    n_asrt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 4'h1) begin n_fail++; $display("FAIL cr_valid got %0b id %h want 1 id 1", bus.rsp_valid, bus.rsp_id); end
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b0 || bus.rsp_rs1_value !== 32'h1234) begin n_fail++; $display("FAIL cr_value got busy %0b %h want 0 1234", bus.rsp_rs1_busy, bus.rsp_rs1_value); end
    n_asrt++; if (bus.rsp_rs2_busy !== 1'b0 || bus.rsp_rs2_value !== 32'h0) begin n_fail++; $display("FAIL cr_disabled got busy %0b %h want 0 0", bus.rsp_rs2_busy, bus.rsp_rs2_value); end
    cyc();
    n_asrt++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL cr_pulse got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_rename_bypass();
    clr(); req(4'h3, 0, 5'd0, 0, 5'd0, 1, 5'd7, 4'd9); cyc();
    clr(); req(4'h4, 1, 5'd7, 0, 5'd0, 0, 5'd0, 4'd0); cyc();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b1 || bus.rsp_rs1_tag !== 4'd9) begin n_fail++; $display("FAIL rn_busy got %0b tag %0d want 1 tag 9", bus.rsp_rs1_busy, bus.rsp_rs1_tag); end
    clr(); req(4'h5, 1, 5'd7, 0, 5'd0, 0, 5'd0, 4'd0); commit(5'd7, 4'd9, 32'hAA); cyc();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b0 || bus.rsp_rs1_value !== 32'hAA) begin n_fail++; $display("FAIL rn_bypass got busy %0b %h want 0 aa", bus.rsp_rs1_busy, bus.rsp_rs1_value); end
    clr(); req(4'h6, 0, 5'd0, 1, 5'd7, 0, 5'd0, 4'd0); cyc(); clr();
    n_asrt++; if (bus.rsp_rs2_busy !== 1'b0 || bus.rsp_rs2_value !== 32'hAA) begin n_fail++; $display("FAIL rn_after got busy %0b %h want 0 aa", bus.rsp_rs2_busy, bus.rsp_rs2_value); end
  endtask

  task automatic test_stale_commit();
    clr(); req(4'h1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 4'd9); cyc();
    clr(); req(4'h2, 0, 5'd0, 0, 5'd0, 1, 5'd7, 4'd11); cyc();
    clr(); commit(5'd7, 4'd9, 32'h55); cyc();
    clr(); req(4'h3, 0, 5'd0, 1, 5'd7, 0, 5'd0, 4'd0); cyc();
    n_asrt++; if (bus.rsp_rs2_busy !== 1'b1 || bus.rsp_rs2_tag !== 4'd11) begin n_fail++; $display("FAIL stale_busy got %0b tag %0d want 1 tag 11", bus.rsp_rs2_busy, bus.rsp_rs2_tag); end
    clr(); commit(5'd7, 4'd11, 32'h66); cyc();
    clr(); req(4'h4, 1, 5'd7, 0, 5'd0, 0, 5'd0, 4'd0); cyc(); clr();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b0 || bus.rsp_rs1_value !== 32'h66) begin n_fail++; $display("FAIL stale_final got busy %0b %h want 0 66", bus.rsp_rs1_busy, bus.rsp_rs1_value); end
  endtask

  task automatic test_x0_selfdep();
    clr(); req(4'h1, 0, 5'd0, 0, 5'd0, 1, 5'd0, 4'd4); commit(5'd0, 4'd0, 32'hDEAD); cyc();
    clr(); req(4'h2, 1, 5'd0, 1, 5'd0, 0, 5'd0, 4'd0); cyc();
    n_asrt++; if ({bus.rsp_rs1_busy, bus.rsp_rs2_busy} !== 2'b00 || bus.rsp_rs1_value !== 32'h0) begin n_fail++; $display("FAIL x0 got busy %b %h want 00 0", {bus.rsp_rs1_busy, bus.rsp_rs2_busy}, bus.rsp_rs1_value); end
    clr(); commit(5'd6, 4'd0, 32'h60); cyc();
    clr(); req(4'h3, 1, 5'd6, 0, 5'd0, 1, 5'd6, 4'd1); cyc();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b0 || bus.rsp_rs1_value !== 32'h60) begin n_fail++; $display("FAIL selfdep_old got busy %0b %h want 0 60", bus.rsp_rs1_busy, bus.rsp_rs1_value); end
    clr(); req(4'h4, 1, 5'd6, 0, 5'd0, 0, 5'd0, 4'd0); cyc(); clr();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b1 || bus.rsp_rs1_tag !== 4'd1) begin n_fail++; $display("FAIL selfdep_new got %0b tag %0d want 1 tag 1", bus.rsp_rs1_busy, bus.rsp_rs1_tag); end
  endtask

  task automatic test_same_cycle();
    clr(); req(4'h1, 0, 5'd0, 0, 5'd0, 1, 5'd8, 4'd5); cyc();
    clr(); req(4'h2, 1, 5'd8, 0, 5'd0, 1, 5'd8, 4'd6); commit(5'd8, 4'd5, 32'h88); cyc();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b0 || bus.rsp_rs1_value !== 32'h88) begin n_fail++; $display("FAIL same_bypass got busy %0b %h want 0 88", bus.rsp_rs1_busy, bus.rsp_rs1_value); end
    clr(); req(4'h3, 1, 5'd8, 0, 5'd0, 0, 5'd0, 4'd0); cyc();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b1 || bus.rsp_rs1_tag !== 4'd6) begin n_fail++; $display("FAIL same_rename got %0b tag %0d want 1 tag 6", bus.rsp_rs1_busy, bus.rsp_rs1_tag); end
    clr(); commit(5'd8, 4'd6, 32'h99); cyc();
    clr(); req(4'h4, 1, 5'd8, 0, 5'd0, 0, 5'd0, 4'd0); cyc(); clr();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b0 || bus.rsp_rs1_value !== 32'h99) begin n_fail++; $display("FAIL same_final got busy %0b %h want 0 99", bus.rsp_rs1_busy, bus.rsp_rs1_value); end
  endtask

  task automatic test_snapshot();
    logic       exp_b4;
    logic [3:0] exp_t4;
`ifdef REG_SNAPSHOT_EN
    exp_b4 = 1'b1; exp_t4 = 4'd7;
`else
    exp_b4 = 1'b0; exp_t4 = 4'd0;
`endif
    clr(); flush = 1; cyc();
    clr(); req(4'h1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 4'd2); cyc();
    clr(); req(4'h2, 0, 5'd0, 0, 5'd0, 1, 5'd4, 4'd7); cyc();
    clr(); snap_take = 1; cyc();
    clr(); req(4'h3, 0, 5'd0, 0, 5'd0, 1, 5'd3, 4'd5); cyc();
    clr(); commit(5'd3, 4'd2, 32'h33); cyc();
    clr(); snap_restore = 1; req(4'h4, 1, 5'd3, 0, 5'd0, 0, 5'd0, 4'd0); cyc();
    n_asrt++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL snap_drop got %0b want 0", bus.rsp_valid); end
    clr(); req(4'h5, 1, 5'd3, 1, 5'd4, 0, 5'd0, 4'd0); cyc();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b0 || bus.rsp_rs1_value !== 32'h33) begin n_fail++; $display("FAIL snap_x3 got busy %0b %h want 0 33", bus.rsp_rs1_busy, bus.rsp_rs1_value); end
    n_asrt++; if (bus.rsp_rs2_busy !== exp_b4 || bus.rsp_rs2_tag !== exp_t4) begin n_fail++; $display("FAIL snap_x4 got %0b tag %0d want %0b tag %0d", bus.rsp_rs2_busy, bus.rsp_rs2_tag, exp_b4, exp_t4); end
    clr(); req(4'h6, 0, 5'd0, 0, 5'd0, 1, 5'd9, 4'd3); cyc();
    clr(); snap_restore = 1; cyc();
    clr(); req(4'h7, 1, 5'd9, 1, 5'd4, 0, 5'd0, 4'd0); cyc(); clr();
    n_asrt++; if ({bus.rsp_rs1_busy, bus.rsp_rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL snap_empty got busy %b want 00", {bus.rsp_rs1_busy, bus.rsp_rs2_busy}); end
  endtask

  task automatic test_flush();
    clr(); req(4'h1, 0, 5'd0, 0, 5'd0, 1, 5'd10, 4'd4); cyc();
    clr(); req(4'h2, 0, 5'd0, 0, 5'd0, 1, 5'd11, 4'd5); cyc();
    clr(); flush = 1; req(4'h3, 1, 5'd10, 0, 5'd0, 1, 5'd13, 4'd1); commit(5'd12, 4'd0, 32'hC0FFEE); cyc();
    n_asrt++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %0b want 0", bus.rsp_valid); end
    clr(); req(4'h4, 1, 5'd10, 1, 5'd11, 0, 5'd0, 4'd0); cyc();
    n_asrt++; if ({bus.rsp_rs1_busy, bus.rsp_rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL flush_busy got %b want 00", {bus.rsp_rs1_busy, bus.rsp_rs2_busy}); end
    clr(); req(4'h5, 1, 5'd12, 1, 5'd13, 0, 5'd0, 4'd0); cyc(); clr();
    n_asrt++; if (bus.rsp_rs1_value !== 32'hC0FFEE || bus.rsp_rs2_busy !== 1'b0) begin n_fail++; $display("FAIL flush_commit got %h busy %0b want c0ffee busy 0", bus.rsp_rs1_value, bus.rsp_rs2_busy); end
  endtask

  task automatic test_rdy();
    clr(); cyc();
    rdy = 0; req(4'h9, 1, 5'd5, 0, 5'd0, 1, 5'd14, 4'd2); commit(5'd5, 4'd3, 32'hBAD); cyc(); cyc();
    n_asrt++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rdy_hold got %0b want 0", bus.rsp_valid); end
    rdy = 1; clr(); req(4'hA, 1, 5'd14, 1, 5'd5, 0, 5'd0, 4'd0); cyc(); clr();
    n_asrt++; if (bus.rsp_rs1_busy !== 1'b0 || bus.rsp_rs2_value !== 32'h1234 || bus.rsp_id !== 4'hA) begin
      n_fail++; $display("FAIL rdy_state got busy %0b val %h id %h want 0 1234 a", bus.rsp_rs1_busy, bus.rsp_rs2_value, bus.rsp_id); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  regs [3];
    logic [31:0] vals [3];
    regs[0] = 5'd5;  vals[0] = 32'h1234;
    regs[1] = 5'd12; vals[1] = 32'hC0FFEE;
    regs[2] = 5'd7;  vals[2] = 32'h66;
    for (int i = 0; i < 3; i++) begin
      clr(); req(4'(i + 1), 1, regs[i], 0, 5'd0, 0, 5'd0, 4'd0); cyc();
      n_asrt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 4'(i + 1) || bus.rsp_rs1_value !== vals[i]) begin
        n_fail++; $display("FAIL b2b_%0d got v%0b id %h %h want 1 %h %h", i, bus.rsp_valid, bus.rsp_id, bus.rsp_rs1_value, 4'(i + 1), vals[i]); end
    end
    clr();
  endtask

  initial begin
    test_reset();
    test_commit_read();
    test_rename_bypass();
    test_stale_commit();
    test_x0_selfdep();
    test_same_cycle();
    test_snapshot();
    test_flush();
    test_rdy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
